// File: rtl/seq_multiplier.sv
// Iterative radix-2 shift-add multiplier for the M-extension datapath.
// Operands are reduced to magnitudes at launch. One partial product is
// accumulated per cycle, and the sign is applied on the last iteration.
module seq_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               launch,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic               a_signed,
  input  logic               b_signed,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   product_lo,
  output logic [WIDTH-1:0]   product_hi
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t               state;
  logic [2*WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]     mplier;
  logic [2*WIDTH-1:0]   acc;
  logic [CW-1:0]        cnt;
  logic                 neg;

  logic                 a_neg, b_neg;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [2*WIDTH-1:0]   acc_next;

  // Launch-time magnitude conversion. The most negative value maps to
  // 2^(WIDTH-1), which still fits in WIDTH unsigned bits.
  always_comb begin
    a_neg = a_signed & multiplicand[WIDTH-1];
    b_neg = b_signed & multiplier[WIDTH-1];
    a_mag = a_neg ? (~multiplicand + 1'b1) : multiplicand;
    b_mag = b_neg ? (~multiplier + 1'b1) : multiplier;
  end

  // Partial-product accumulate for the current iteration.
  always_comb begin
    acc_next = acc + (mplier[0] ? mcand : '0);
  end

  // Control FSM and datapath. Priority is reset, then launch, then iteration.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
      neg     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else if (launch) begin
      // A launch while running aborts the run; product keeps the last result.
      state  <= RUN;
      mcand  <= {{WIDTH{1'b0}}, a_mag};
      mplier <= b_mag;
      acc    <= '0;
      cnt    <= '0;
      neg    <= a_neg ^ b_neg;
      busy   <= 1'b1;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == RUN) begin
        acc    <= acc_next;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
        if (cnt == LAST) begin
          product <= neg ? (~acc_next + 1'b1) : acc_next;
          state   <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b1;
        end
      end
    end
  end

  assign product_lo = product[WIDTH-1:0];
  assign product_hi = product[2*WIDTH-1:WIDTH];

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier at WIDTH=4. It uses directed
// vectors, abort/reset sequences, and random operands compared against an
// integer-arithmetic reference.
module tb_seq_multiplier;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic           launch;
  logic [W-1:0]   multiplicand, multiplier;
  logic           a_signed, b_signed;
  logic           busy, done;
  logic [2*W-1:0] product;
  logic [W-1:0]   product_lo, product_hi;

  int errors = 0;
  int checks = 0;
  logic [2*W-1:0] prev;

  seq_multiplier #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .launch(launch),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .a_signed(a_signed), .b_signed(b_signed),
    .busy(busy), .done(done), .product(product),
    .product_lo(product_lo), .product_hi(product_hi)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]   a, b;
    logic           as, bs;
    logic [2*W-1:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: interpret operands as integers and take the low 2W bits of the product.
  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic as, input logic bs);
    longint av, bv, p;
    av = longint'(a);
    bv = longint'(b);
    if (as && a[W-1]) av = av - (longint'(1) << W);
    if (bs && b[W-1]) bv = bv - (longint'(1) << W);
    p = av * bv;
    return p[2*W-1:0];
  endfunction

  // Launch one operation and check the state right after the launch edge.
  // The operand inputs are then scrambled to show that they are sampled only once.
  task automatic start(input logic [W-1:0] a, input logic [W-1:0] b, input logic as, input logic bs);
    @(negedge clk);
    multiplicand = a; multiplier = b; a_signed = as; b_signed = bs; launch = 1'b1;
    @(posedge clk); #1;
    launch = 1'b0;
    chk("launch_busy", busy, 1);
    chk("launch_done", done, 0);
    chk("launch_product_hold", product, prev);
    multiplicand = W'($urandom); multiplier = W'($urandom);
    a_signed = 1'($urandom); b_signed = 1'($urandom);
  endtask

  // Step through the remaining busy cycles and check the done edge.
  task automatic finish(input logic [2*W-1:0] exp);
    for (int k = 1; k < W; k++) begin
      @(posedge clk); #1;
      chk("run_busy", busy, 1);
      chk("run_done", done, 0);
      chk("run_product_hold", product, prev);
    end
    @(posedge clk); #1;
    chk("end_busy", busy, 0);
    chk("end_done", done, 1);
    chk("end_product", product, exp);
    chk("end_hi", product_hi, exp[2*W-1:W]);
    chk("end_lo", product_lo, exp[W-1:0]);
    prev = exp;
  endtask

  vec_t vt[7];

  initial begin
    vt[0] = '{4'd13, 4'd11, 1'b0, 1'b0, 8'h8F};
    vt[1] = '{4'hD,  4'h5,  1'b1, 1'b1, 8'hF1};
    vt[2] = '{4'h8,  4'h8,  1'b1, 1'b1, 8'h40};
    vt[3] = '{4'hF,  4'hF,  1'b1, 1'b0, 8'hF1};
    vt[4] = '{4'hF,  4'hF,  1'b0, 1'b0, 8'hE1};
    vt[5] = '{4'h0,  4'h7,  1'b0, 1'b0, 8'h00};
    vt[6] = '{4'h8,  4'hF,  1'b1, 1'b1, 8'h08};

    reset = 1'b1; launch = 1'b0;
    multiplicand = '0; multiplier = '0; a_signed = 1'b0; b_signed = 1'b0;
    prev = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_product", product, 0);
    @(negedge clk); reset = 1'b0;

    // Directed vectors
    for (int i = 0; i < 7; i++) begin
      start(vt[i].a, vt[i].b, vt[i].as, vt[i].bs);
      finish(vt[i].exp);
    end
    @(posedge clk); #1;
    chk("done_single_pulse", done, 0);

    // Abort: a second launch arrives during the second busy cycle.
    start(4'd13, 4'd11, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("abort_pre_product", product, prev);
    start(4'd2, 4'd3, 1'b0, 1'b0);
    finish(8'h06);

    // Launch in the same cycle that done is high.
    start(4'd7, 4'd9, 1'b0, 1'b0);
    finish(8'h3F);
    start(4'd3, 4'hE, 1'b0, 1'b1);
    finish(8'hFA);

    // Reset asserted during the third busy cycle.
    start(4'd13, 4'd11, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    chk("midreset_busy", busy, 0);
    chk("midreset_done", done, 0);
    chk("midreset_product", product, 0);
    prev = '0;
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    chk("postreset_idle", busy, 0);
    start(4'd5, 4'd5, 1'b0, 1'b0);
    finish(8'h19);

    // Random operands compared against the integer reference
    for (int i = 0; i < 60; i++) begin
      logic [W-1:0] ra, rb;
      logic rs_a, rs_b;
      ra = W'($urandom); rb = W'($urandom);
      rs_a = 1'($urandom); rs_b = 1'($urandom);
      start(ra, rb, rs_a, rs_b);
      finish(model(ra, rb, rs_a, rs_b));
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
        chk("rand_done_drop", done, 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
